// File: rtl/instr_sequencer.sv
// instr_sequencer: Moore control FSM for a 16-bit register/ALU datapath.
// Holds the instruction register and drives registered, one-cycle datapath strobes.
module instr_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic [1:0]  vsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_GET_A,
        S_GET_B,
        S_ALU,
        S_WRITE_REG,
        S_WRITE_IMM
    } state_e;

    typedef enum logic [2:0] {
        I_MOV_IMM,
        I_MOV_REG,
        I_MVN,
        I_ADD,
        I_AND,
        I_CMP,
        I_NONE
    } instr_e;

    localparam logic [1:0] VSEL_C    = 2'b00;
    localparam logic [1:0] VSEL_IMM8 = 2'b10;

    state_e      state_q;
    logic [15:0] ir_q;
    instr_e      kind;

    logic [2:0]  readnum_q;
    logic [2:0]  writenum_q;
    logic        write_q;
    logic        loada_q;
    logic        loadb_q;
    logic        loadc_q;
    logic        loads_q;
    logic        asel_q;
    logic [1:0]  vsel_q;
    logic [1:0]  shift_q;
    logic [1:0]  aluop_q;

    logic [2:0]  rn;
    logic [2:0]  rd;
    logic [2:0]  rm;
    logic [1:0]  sh;
    logic [1:0]  op;

    assign op = ir_q[12:11];
    assign rn = ir_q[10:8];
    assign rd = ir_q[7:5];
    assign sh = ir_q[4:3];
    assign rm = ir_q[2:0];

    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        kind = I_NONE;
        case ({ir_q[15:13], ir_q[12:11]})
            5'b110_10: kind = I_MOV_IMM;
            5'b110_00: kind = I_MOV_REG;
            5'b101_11: kind = I_MVN;
            5'b101_00: kind = I_ADD;
            5'b101_10: kind = I_AND;
            5'b101_01: kind = I_CMP;
            default:   kind = I_NONE;
        endcase
    end

    // Outputs are registered alongside the state: each arm loads the values for the state it enters.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_WAIT;
            ir_q       <= '0;
            readnum_q  <= '0;
            writenum_q <= '0;
            write_q    <= 1'b0;
            loada_q    <= 1'b0;
            loadb_q    <= 1'b0;
            loadc_q    <= 1'b0;
            loads_q    <= 1'b0;
            asel_q     <= 1'b0;
            vsel_q     <= '0;
            shift_q    <= '0;
            aluop_q    <= '0;
        end else begin
            readnum_q  <= '0;
            writenum_q <= '0;
            write_q    <= 1'b0;
            loada_q    <= 1'b0;
            loadb_q    <= 1'b0;
            loadc_q    <= 1'b0;
            loads_q    <= 1'b0;
            asel_q     <= 1'b0;
            vsel_q     <= '0;
            shift_q    <= '0;
            aluop_q    <= '0;

            case (state_q)
                S_WAIT: begin
                    if (load) begin
                        ir_q <= in;
                    end
                    if (s) begin
                        state_q <= S_DECODE;
                    end
                end

                S_DECODE: begin
                    case (kind)
                        I_MOV_IMM: begin
                            state_q    <= S_WRITE_IMM;
                            write_q    <= 1'b1;
                            writenum_q <= rn;
                            vsel_q     <= VSEL_IMM8;
                        end
                        I_MOV_REG, I_MVN: begin
                            state_q   <= S_GET_B;
                            loadb_q   <= 1'b1;
                            readnum_q <= rm;
                        end
                        I_ADD, I_AND, I_CMP: begin
                            state_q   <= S_GET_A;
                            loada_q   <= 1'b1;
                            readnum_q <= rn;
                        end
                        default: state_q <= S_WAIT;
                    endcase
                end

                S_GET_A: begin
                    state_q   <= S_GET_B;
                    loadb_q   <= 1'b1;
                    readnum_q <= rm;
                end

                S_GET_B: begin
                    state_q <= S_ALU;
                    shift_q <= sh;
                    if (kind == I_MOV_REG) begin
                        aluop_q <= 2'b00;
                        asel_q  <= 1'b1;
                    end else begin
                        aluop_q <= op;
                    end
                    // CMP only updates status; its result never reaches C.
                    if (kind == I_CMP) begin
                        loads_q <= 1'b1;
                    end else begin
                        loadc_q <= 1'b1;
                    end
                end

                S_ALU: begin
                    if (kind == I_CMP) begin
                        state_q <= S_WAIT;
                    end else begin
                        state_q    <= S_WRITE_REG;
                        write_q    <= 1'b1;
                        writenum_q <= rd;
                        vsel_q     <= VSEL_C;
                    end
                end

                S_WRITE_REG, S_WRITE_IMM: state_q <= S_WAIT;

                default: state_q <= S_WAIT;
            endcase
        end
    end

    assign w        = (state_q == S_WAIT);
    assign readnum  = readnum_q;
    assign writenum = writenum_q;
    assign write    = write_q;
    assign loada    = loada_q;
    assign loadb    = loadb_q;
    assign loadc    = loadc_q;
    assign loads    = loads_q;
    assign asel     = asel_q;
    assign vsel     = vsel_q;
    assign shift    = shift_q;
    assign ALUop    = aluop_q;
    assign sximm8   = {{8{ir_q[7]}}, ir_q[7:0]};
    assign sximm5   = {{11{ir_q[4]}}, ir_q[4:0]};

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: stimulus queues hand-computed per-cycle outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_instr_sequencer;

    logic        clk;
    logic        reset;
    logic        s;
    logic        load;
    logic [15:0] instr_in;
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic [1:0]  vsel;
    logic [1:0]  shift;
    logic [1:0]  aluop;
    logic [15:0] sximm8;
    logic [15:0] sximm5;

    instr_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .s        (s),
        .load     (load),
        .in       (instr_in),
        .w        (w),
        .readnum  (readnum),
        .writenum (writenum),
        .write    (write),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .asel     (asel),
        .vsel     (vsel),
        .shift    (shift),
        .ALUop    (aluop),
        .sximm8   (sximm8),
        .sximm5   (sximm5)
    );

    typedef struct packed {
        logic        w;
        logic [2:0]  readnum;
        logic [2:0]  writenum;
        logic        write;
        logic        loada;
        logic        loadb;
        logic        loadc;
        logic        loads;
        logic        asel;
        logic [1:0]  vsel;
        logic [1:0]  shift;
        logic [1:0]  aluop;
        logic [15:0] sximm8;
        logic [15:0] sximm5;
    } vec_t;

    vec_t  exp_q[$];
    string name_q[$];
    int    vectors     = 0;
    int    miscompares = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t f_base(input logic wv, input logic [15:0] x8, input logic [15:0] x5);
        vec_t v;
        v        = '0;
        v.w      = wv;
        v.sximm8 = x8;
        v.sximm5 = x5;
        return v;
    endfunction

    function automatic vec_t f_idle(input logic [15:0] x8, input logic [15:0] x5);
        return f_base(1'b1, x8, x5);
    endfunction

    function automatic vec_t f_dec(input logic [15:0] x8, input logic [15:0] x5);
        return f_base(1'b0, x8, x5);
    endfunction

    function automatic vec_t f_geta(input logic [2:0] r, input logic [15:0] x8, input logic [15:0] x5);
        vec_t v;
        v         = f_base(1'b0, x8, x5);
        v.readnum = r;
        v.loada   = 1'b1;
        return v;
    endfunction

    function automatic vec_t f_getb(input logic [2:0] r, input logic [15:0] x8, input logic [15:0] x5);
        vec_t v;
        v         = f_base(1'b0, x8, x5);
        v.readnum = r;
        v.loadb   = 1'b1;
        return v;
    endfunction

    function automatic vec_t f_alu(input logic [1:0] sh, input logic [1:0] op, input logic as,
                                   input logic lc, input logic ls,
                                   input logic [15:0] x8, input logic [15:0] x5);
        vec_t v;
        v       = f_base(1'b0, x8, x5);
        v.shift = sh;
        v.aluop = op;
        v.asel  = as;
        v.loadc = lc;
        v.loads = ls;
        return v;
    endfunction

    function automatic vec_t f_wreg(input logic [2:0] r, input logic [15:0] x8, input logic [15:0] x5);
        vec_t v;
        v          = f_base(1'b0, x8, x5);
        v.write    = 1'b1;
        v.writenum = r;
        v.vsel     = 2'b00;
        return v;
    endfunction

    function automatic vec_t f_wimm(input logic [2:0] r, input logic [15:0] x8, input logic [15:0] x5);
        vec_t v;
        v          = f_base(1'b0, x8, x5);
        v.write    = 1'b1;
        v.writenum = r;
        v.vsel     = 2'b10;
        return v;
    endfunction

    // Expectation describes the DUT outputs after the coming rising edge.
    task automatic tick(input string name, input vec_t e);
        @(posedge clk);
        exp_q.push_back(e);
        name_q.push_back(name);
        #1;
    endtask

    task automatic drive(input logic sv, input logic lv, input logic [15:0] iv);
        s        = sv;
        load     = lv;
        instr_in = iv;
    endtask

    vec_t  mon_exp;
    vec_t  mon_act;
    string mon_name;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            mon_act  = {w, readnum, writenum, write, loada, loadb, loadc, loads, asel,
                        vsel, shift, aluop, sximm8, sximm5};
            vectors++;
            if (mon_act !== mon_exp) begin
                miscompares++;
                $display("FAIL %s: got %h expected %h", mon_name, mon_act, mon_exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        drive(1'b0, 1'b0, 16'h0000);
        tick("reset_0", f_idle(16'h0000, 16'h0000));
        tick("reset_1", f_idle(16'h0000, 16'h0000));
        reset = 1'b1;

        // MOV R0,#7 on the very first edge after reset, load and s together.
        drive(1'b1, 1'b1, 16'hD007);
        tick("movi7_decode", f_dec(16'h0007, 16'h0007));
        drive(1'b0, 1'b0, 16'h0000);
        tick("movi7_wimm", f_wimm(3'd0, 16'h0007, 16'h0007));
        tick("movi7_wait", f_idle(16'h0007, 16'h0007));
        tick("idle_hold", f_idle(16'h0007, 16'h0007));

        // MOV R1,#-2 loaded alone, then s held high re-runs it.
        drive(1'b0, 1'b1, 16'hD1FE);
        tick("movim2_load", f_idle(16'hFFFE, 16'hFFFE));
        drive(1'b1, 1'b0, 16'h0000);
        tick("movim2_decode", f_dec(16'hFFFE, 16'hFFFE));
        tick("movim2_wimm", f_wimm(3'd1, 16'hFFFE, 16'hFFFE));
        tick("movim2_wait", f_idle(16'hFFFE, 16'hFFFE));
        tick("movim2_redecode", f_dec(16'hFFFE, 16'hFFFE));
        drive(1'b0, 1'b0, 16'h0000);
        tick("movim2_rewimm", f_wimm(3'd1, 16'hFFFE, 16'hFFFE));
        tick("movim2_rewait", f_idle(16'hFFFE, 16'hFFFE));

        // ADD R2,R1,R0,LSL#1 with a stray load of 0xFFFF mid-instruction.
        drive(1'b1, 1'b1, 16'hA148);
        tick("add_decode", f_dec(16'h0048, 16'h0008));
        drive(1'b0, 1'b0, 16'h0000);
        tick("add_geta", f_geta(3'd1, 16'h0048, 16'h0008));
        drive(1'b0, 1'b1, 16'hFFFF);
        tick("add_getb", f_getb(3'd0, 16'h0048, 16'h0008));
        tick("add_alu", f_alu(2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 16'h0048, 16'h0008));
        drive(1'b0, 1'b0, 16'h0000);
        tick("add_wreg", f_wreg(3'd2, 16'h0048, 16'h0008));
        tick("add_wait", f_idle(16'h0048, 16'h0008));

        // CMP R1,R0: status load only.
        drive(1'b1, 1'b1, 16'hA900);
        tick("cmp_decode", f_dec(16'h0000, 16'h0000));
        drive(1'b0, 1'b0, 16'h0000);
        tick("cmp_geta", f_geta(3'd1, 16'h0000, 16'h0000));
        tick("cmp_getb", f_getb(3'd0, 16'h0000, 16'h0000));
        tick("cmp_alu", f_alu(2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000));
        tick("cmp_wait", f_idle(16'h0000, 16'h0000));

        // MVN R5,R3.
        drive(1'b1, 1'b1, 16'hB8A3);
        tick("mvn_decode", f_dec(16'hFFA3, 16'h0003));
        drive(1'b0, 1'b0, 16'h0000);
        tick("mvn_getb", f_getb(3'd3, 16'hFFA3, 16'h0003));
        tick("mvn_alu", f_alu(2'b00, 2'b11, 1'b0, 1'b1, 1'b0, 16'hFFA3, 16'h0003));
        tick("mvn_wreg", f_wreg(3'd5, 16'hFFA3, 16'h0003));
        tick("mvn_wait", f_idle(16'hFFA3, 16'h0003));

        // MOV R6,R4,ASR-style sh=10: ALU passes B with asel.
        drive(1'b1, 1'b1, 16'hC0D4);
        tick("movr_decode", f_dec(16'hFFD4, 16'hFFF4));
        drive(1'b0, 1'b0, 16'h0000);
        tick("movr_getb", f_getb(3'd4, 16'hFFD4, 16'hFFF4));
        tick("movr_alu", f_alu(2'b10, 2'b00, 1'b1, 1'b1, 1'b0, 16'hFFD4, 16'hFFF4));
        tick("movr_wreg", f_wreg(3'd6, 16'hFFD4, 16'hFFF4));
        tick("movr_wait", f_idle(16'hFFD4, 16'hFFF4));

        // AND R1,R3,R2,sh=11.
        drive(1'b1, 1'b1, 16'hB33A);
        tick("and_decode", f_dec(16'h003A, 16'hFFFA));
        drive(1'b0, 1'b0, 16'h0000);
        tick("and_geta", f_geta(3'd3, 16'h003A, 16'hFFFA));
        tick("and_getb", f_getb(3'd2, 16'h003A, 16'hFFFA));
        tick("and_alu", f_alu(2'b11, 2'b10, 1'b0, 1'b1, 1'b0, 16'h003A, 16'hFFFA));
        tick("and_wreg", f_wreg(3'd1, 16'h003A, 16'hFFFA));
        tick("and_wait", f_idle(16'h003A, 16'hFFFA));

        // Undefined encodings fall straight back to WAIT.
        drive(1'b1, 1'b1, 16'hE000);
        tick("undef_e000_decode", f_dec(16'h0000, 16'h0000));
        drive(1'b0, 1'b0, 16'h0000);
        tick("undef_e000_wait", f_idle(16'h0000, 16'h0000));
        drive(1'b1, 1'b1, 16'hC800);
        tick("undef_c800_decode", f_dec(16'h0000, 16'h0000));
        drive(1'b0, 1'b0, 16'h0000);
        tick("undef_c800_wait", f_idle(16'h0000, 16'h0000));

        // Reset asserted while an ADD sits in ALU: immediate return to idle, no write.
        drive(1'b1, 1'b1, 16'hA148);
        tick("radd_decode", f_dec(16'h0048, 16'h0008));
        drive(1'b0, 1'b0, 16'h0000);
        tick("radd_geta", f_geta(3'd1, 16'h0048, 16'h0008));
        tick("radd_getb", f_getb(3'd0, 16'h0048, 16'h0008));
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.push_back(f_idle(16'h0000, 16'h0000));
        name_q.push_back("radd_async_reset");
        tick("radd_reset_hold", f_idle(16'h0000, 16'h0000));
        reset = 1'b1;
        tick("radd_after_release", f_idle(16'h0000, 16'h0000));
        tick("radd_still_idle", f_idle(16'h0000, 16'h0000));

        repeat (3) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
